// File: rtl/redun_to_axi.sv
// Converts one redundant-form Montgomery result into a stream of normalized
// AXI_LEN-bit beats, LSB first, resolving inter-word carries two words per beat.
module redun_to_axi #(
    parameter int WRD_BITS = 16,
    parameter int NUM_WRDS = 65,
    parameter int AXI_LEN  = 32
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_WRDS*(WRD_BITS+1)-1:0] i_dat,
    input  logic                             i_val,
    output logic                             o_rdy,
    output logic [AXI_LEN-1:0]               o_dat,
    output logic                             o_val,
    input  logic                             i_rdy,
    output logic                             o_last,
    output logic [1:0]                       o_ovf
);
    localparam int RW   = WRD_BITS + 1;
    localparam int SW   = WRD_BITS + 2;
    localparam int IDXW = $clog2(NUM_WRDS + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q;
    logic [IDXW-1:0] idx_q;
    logic [1:0]      carry_q;
    logic [RW-1:0]   wrd_q   [NUM_WRDS];
    logic [RW-1:0]   in_wrd  [NUM_WRDS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WRDS; gi++) begin : g_unpack
            assign in_wrd[gi] = i_dat[gi*RW +: RW];
        end
    endgenerate

    logic capture;
    assign capture = (state_q == IDLE) && i_val;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_WRDS; k++) wrd_q[k] <= '0;
        end else if (capture) begin
            wrd_q <= in_wrd;
        end
    end

    logic [IDXW-1:0] idx_hi;
    logic            has_hi;
    logic            last;
    logic [RW-1:0]   w_lo;
    logic [RW-1:0]   w_hi;
    logic [SW-1:0]   s0;
    logic [SW-1:0]   s1;
    logic [1:0]      carry_out;
    logic            send;

    assign idx_hi = idx_q + IDXW'(1);
    // With an odd word count the final beat carries only the top word.
    assign has_hi = idx_q < IDXW'(NUM_WRDS - 1);
    assign last   = idx_q >= IDXW'(NUM_WRDS - 2);
    assign w_lo   = wrd_q[idx_q];
    assign w_hi   = has_hi ? wrd_q[idx_hi] : '0;

    assign s0 = SW'(w_lo) + SW'(carry_q);
    assign s1 = SW'(w_hi) + SW'(s0[SW-1:WRD_BITS]);

    assign carry_out = has_hi ? s1[SW-1:WRD_BITS] : s0[SW-1:WRD_BITS];
    assign send      = (state_q == SEND);

    assign o_val  = send;
    assign o_rdy  = !send;
    assign o_last = send && last;
    assign o_ovf  = (send && last) ? carry_out : 2'b00;
    assign o_dat  = send ? {(has_hi ? s1[WRD_BITS-1:0] : {WRD_BITS{1'b0}}), s0[WRD_BITS-1:0]}
                         : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_val) begin
                        idx_q   <= '0;
                        carry_q <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (i_rdy) begin
                        if (last) begin
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= idx_q + IDXW'(2);
                            carry_q <= carry_out;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_redun_to_axi.sv
// Scoreboard bench: expected beats come from an arithmetic sum of the redundant
// words and are popped as the DUT hands off each beat.
module tb_redun_to_axi;
    localparam int WRD_BITS = 16;
    localparam int NUM_WRDS = 65;
    localparam int AXI_LEN  = 32;
    localparam int RW       = WRD_BITS + 1;
    localparam int NBEATS   = (NUM_WRDS + 1) / 2;

    logic                    clk = 1'b0;
    logic                    i_rst;
    logic [NUM_WRDS*RW-1:0]  i_dat;
    logic                    i_val;
    logic                    o_rdy;
    logic [AXI_LEN-1:0]      o_dat;
    logic                    o_val;
    logic                    i_rdy;
    logic                    o_last;
    logic [1:0]              o_ovf;

    redun_to_axi #(.WRD_BITS(WRD_BITS), .NUM_WRDS(NUM_WRDS), .AXI_LEN(AXI_LEN)) dut (
        .i_clk (clk),
        .i_rst (i_rst),
        .i_dat (i_dat),
        .i_val (i_val),
        .o_rdy (o_rdy),
        .o_dat (o_dat),
        .o_val (o_val),
        .i_rdy (i_rdy),
        .o_last(o_last),
        .o_ovf (o_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] dat;
        logic        last;
        logic [1:0]  ovf;
    } beat_t;

    beat_t       sb [$];
    logic [16:0] w  [NUM_WRDS];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pack_and_push();
        logic [1055:0] acc;
        beat_t         b;
        acc = '0;
        for (int k = 0; k < NUM_WRDS; k++) begin
            i_dat[k*RW +: RW] = w[k];
            acc = acc + (1056'(w[k]) << (16 * k));
        end
        for (int n = 0; n < NBEATS; n++) begin
            b.dat  = (n == NBEATS - 1) ? {16'h0, acc[1039:1024]} : acc[32*n +: 32];
            b.last = (n == NBEATS - 1);
            b.ovf  = (n == NBEATS - 1) ? acc[1041:1040] : 2'b00;
            sb.push_back(b);
        end
    endtask

    task automatic run_frame(input string name, input bit rnd_rdy, input bit hold_val,
                             input int abort_at);
        int    beats;
        bit    done;
        bit    have_prev;
        beat_t prev;
        beat_t e;
        @(negedge clk);
        pack_and_push();
        i_val = 1'b1;
        chk({name, "_rdy_before_capture"}, o_rdy, 1);
        @(negedge clk);
        if (!hold_val) i_val = 1'b0;
        chk({name, "_first_beat_latency"}, {o_val, o_rdy}, 2'b10);
        beats = 0;
        done = 0;
        have_prev = 0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (have_prev) begin
                chk({name, "_hold_dat"}, o_dat, prev.dat);
                chk({name, "_hold_last_ovf"}, {o_last, o_ovf}, {prev.last, prev.ovf});
                have_prev = 0;
            end
            if (abort_at >= 0 && beats == abort_at) begin
                i_val = 1'b0;
                i_rst = 1'b1;
                #1;
                chk({name, "_abort_val_rdy_last"}, {o_val, o_rdy, o_last}, 3'b010);
                sb.delete();
                #1 i_rst = 1'b0;
                done = 1;
            end else begin
                i_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                chk({name, "_val_in_frame"}, o_val, 1);
                if (i_rdy) begin
                    if (sb.size() == 0) begin
                        chk({name, "_unexpected_beat"}, o_val, 0);
                        done = 1;
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("%s_beat%0d_dat", name, beats), o_dat, e.dat);
                        chk($sformatf("%s_beat%0d_last", name, beats), o_last, e.last);
                        chk($sformatf("%s_beat%0d_ovf", name, beats), o_ovf, e.ovf);
                        beats++;
                        done = e.last;
                    end
                end else begin
                    prev = '{dat: o_dat, last: o_last, ovf: o_ovf};
                    have_prev = 1;
                end
            end
        end
        chk({name, "_frame_done"}, done, 1);
        @(negedge clk);
        i_val = 1'b0;
        i_rdy = 1'b0;
        if (abort_at < 0) begin
            chk({name, "_beat_count"}, beats, NBEATS);
            chk({name, "_sb_empty"}, sb.size(), 0);
        end
        chk({name, "_idle_after"}, {o_val, o_rdy}, 2'b01);
        $display("frame %s beats=%0d errors=%0d", name, beats, errors);
    endtask

    initial begin
        i_rst = 1'b1;
        i_val = 1'b0;
        i_rdy = 1'b0;
        i_dat = '0;
        repeat (2) @(negedge clk);
        chk("reset_rdy_val", {o_rdy, o_val}, 2'b10);
        chk("reset_last_ovf", {o_last, o_ovf}, 3'b000);
        chk("reset_dat", o_dat, 0);
        i_rst = 1'b0;

        for (int k = 0; k < NUM_WRDS; k++) w[k] = '0;
        run_frame("zeros", 1'b0, 1'b0, -1);

        w[0] = 17'h10000;
        run_frame("word0_carry", 1'b0, 1'b0, -1);

        for (int k = 0; k < NUM_WRDS; k++) w[k] = 17'h1FFFF;
        run_frame("all_ones", 1'b0, 1'b0, -1);

        for (int k = 0; k < NUM_WRDS; k++) w[k] = {1'b0, 16'($urandom)};
        run_frame("plain_p", 1'b0, 1'b0, -1);

        for (int k = 0; k < NUM_WRDS; k++) w[k] = 17'h1FFFF;
        run_frame("backpressure", 1'b1, 1'b1, -1);

        for (int k = 0; k < NUM_WRDS; k++) w[k] = {1'($urandom), 16'($urandom)};
        run_frame("random_redun", 1'b1, 1'b0, -1);

        for (int k = 0; k < NUM_WRDS; k++) w[k] = 17'h1FFFF;
        run_frame("abort", 1'b0, 1'b0, 10);

        for (int k = 0; k < NUM_WRDS; k++) w[k] = '0;
        run_frame("after_abort", 1'b0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
